// File: rtl/wb_pkg.sv
// wb_pkg: shared datapath width, load encodings and load-queue entry layout
package wb_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lq_entry_t;
endpackage

// File: rtl/load_align.sv
// load_align: combinational load formatter (lane select + sign/zero extension)
// Ports: funct3_i/addr_lo_i/rdata_i describe the load and raw word;
//        data_o is the formatted value, misalign_o flags a bad offset,
//        illegal_o flags an undefined funct3 (data_o forced to zero).
module load_align #(
  parameter int W = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [1:0]   addr_lo_i,
  input  logic [W-1:0] rdata_i,
  output logic [W-1:0] data_o,
  output logic         misalign_o,
  output logic         illegal_o
);
  import wb_pkg::*;
  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b, is_h, is_w, sgn;
  always_comb begin
    b          = rdata_i[{addr_lo_i, 3'b000} +: 8];
    h          = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    is_b       = funct3_i == LB || funct3_i == LBU;
    is_h       = funct3_i == LH || funct3_i == LHU;
    is_w       = funct3_i == LW;
    sgn        = !funct3_i[2];
    illegal_o  = !(is_b || is_h || is_w);
    misalign_o = (is_h && addr_lo_i[0]) || (is_w && addr_lo_i != 2'b00);
    data_o     = is_b ? {{(W-8){sgn & b[7]}}, b} :
                 is_h ? {{(W-16){sgn & h[15]}}, h} :
                 is_w ? rdata_i : '0;
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: register-file write port merging ALU results and in-order load responses
// Ports: alu_* ALU result handshake; ld_issue_* load issue handshake (queued);
//        mem_rvalid/mem_rdata un-stallable load response; rf_* registered RF write;
//        busy per-register pending-load scoreboard; err sticky error.
// Optional: define WB_PERF_COUNT_EN to add ld_retired_cnt and alu_stall_cnt outputs.
module writeback_unit #(
  parameter int XLEN     = wb_pkg::XLEN,
  parameter int NREG     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue_valid,
  output logic            ld_issue_ready,
  input  logic [4:0]      ld_issue_rd,
  input  logic [2:0]      ld_issue_funct3,
  input  logic [1:0]      ld_issue_addr_lo,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic [NREG-1:0] busy,
  output logic            err
`ifdef WB_PERF_COUNT_EN
  ,
  output logic [31:0]     ld_retired_cnt,
  output logic [31:0]     alu_stall_cnt
`endif
);
  import wb_pkg::*;
  localparam int PW = $clog2(LQ_DEPTH);
  lq_entry_t       lq_q [LQ_DEPTH];
  lq_entry_t       head;
  logic [PW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            rf_en_q, rf_en_d, err_q, err_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d, fmt;
  logic            empty, full, push, pop, alu_fire, misalign, illegal;
  assign head = lq_q[rd_q[PW-1:0]];
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty          = wr_q == rd_q;
  assign full           = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
  assign pop            = mem_rvalid && !empty;
  assign ld_issue_ready = !full && !busy_q[ld_issue_rd];
  assign alu_ready      = !pop && !busy_q[alu_rd];
  assign push           = ld_issue_valid && ld_issue_ready;
  assign alu_fire       = alu_valid && alu_ready;
  load_align #(.W(XLEN)) u_align (
    .funct3_i  (head.funct3),
    .addr_lo_i (head.addr_lo),
    .rdata_i   (mem_rdata),
    .data_o    (fmt),
    .misalign_o(misalign),
    .illegal_o (illegal)
  );
  always_comb begin
    wr_d      = wr_q + {{PW{1'b0}}, push};
    rd_d      = rd_q + {{PW{1'b0}}, pop};
    busy_d    = busy_q;
    err_d     = err_q | (mem_rvalid & empty) | (pop & (misalign | illegal));
    rf_en_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (pop) begin
      rf_en_d           = head.rd != 5'd0;
      rf_rd_d           = head.rd;
      rf_data_d         = illegal ? '0 : fmt;
      busy_d[head.rd]   = 1'b0;
    end else if (alu_fire) begin
      rf_en_d   = alu_rd != 5'd0;
      rf_rd_d   = alu_rd;
      rf_data_d = alu_data;
    end
    // Issue to a register already busy is blocked, so set-after-clear never collides.
    if (push && ld_issue_rd != 5'd0) busy_d[ld_issue_rd] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
      rf_en_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      rf_en_q   <= rf_en_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) lq_q[wr_q[PW-1:0]] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, addr_lo: ld_issue_addr_lo};
  end
  assign rf_en   = rf_en_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;
  assign busy    = busy_q;
  assign err     = err_q;
`ifdef WB_PERF_COUNT_EN
  logic [31:0] ld_cnt_q, stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      ld_cnt_q    <= ld_cnt_q + {31'd0, pop};
      stall_cnt_q <= stall_cnt_q + {31'd0, alu_valid && !alu_ready};
    end
  end
  assign ld_retired_cnt = ld_cnt_q;
  assign alu_stall_cnt  = stall_cnt_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed and randomized checks of writeback_unit against a queue-based model
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic [2:0]  ld_issue_funct3;
  logic [1:0]  ld_issue_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic        err;
`ifdef WB_PERF_COUNT_EN
  logic [31:0] ld_retired_cnt, alu_stall_cnt;
`endif
  always #5 clk = ~clk;
  writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready), .ld_issue_rd(ld_issue_rd),
    .ld_issue_funct3(ld_issue_funct3), .ld_issue_addr_lo(ld_issue_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data), .busy(busy), .err(err)
`ifdef WB_PERF_COUNT_EN
    , .ld_retired_cnt(ld_retired_cnt), .alu_stall_cnt(alu_stall_cnt)
`endif
  );
  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] alo; } ld_t;
  ld_t         mq[$];
  int          tests = 0, fails = 0;
  bit          m_err, m_en, exp_ar, exp_lr, got_ar, got_lr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  function automatic logic [31:0] m_busy();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
    return m;
  endfunction
  function automatic void ref_fmt(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] w,
                                  output logic [31:0] d, output bit bad);
    int unsigned a = alo;
    int unsigned b = (w >> (8 * a)) & 32'hFF;
    int unsigned h = (w >> (16 * (a / 2))) & 32'hFFFF;
    bad = 0;
    case (f3)
      3'd0: d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: d = b;
      3'd1: begin d = (h >= 32768) ? h + 32'hFFFF_0000 : h; bad = (a % 2) != 0; end
      3'd5: begin d = h; bad = (a % 2) != 0; end
      3'd2: begin d = w; bad = a != 0; end
      default: begin d = 0; bad = 1; end
    endcase
  endfunction
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] lf3, input logic [1:0] la,
                       input bit rv, input logic [31:0] rw);
    logic [31:0] bm, d;
    bit bad;
    ld_t e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue_valid = lv; ld_issue_rd = lrd; ld_issue_funct3 = lf3; ld_issue_addr_lo = la;
    mem_rvalid = rv; mem_rdata = rw;
    #1;
    bm = m_busy();
    exp_ar = !(rv && mq.size() != 0) && !bm[ard];
    exp_lr = mq.size() < 2 && !bm[lrd];
    got_ar = alu_ready;
    got_lr = ld_issue_ready;
    m_en = 0;
    if (rv && mq.size() == 0) m_err = 1;
    if (rv && mq.size() != 0) begin
      e = mq.pop_front();
      ref_fmt(e.f3, e.alo, rw, d, bad);
      m_en = e.rd != 0; m_rd = e.rd; m_data = d;
      if (bad) m_err = 1;
    end else if (av && exp_ar) begin
      m_en = ard != 0; m_rd = ard; m_data = ad;
    end
    if (lv && exp_lr) mq.push_back('{rd: lrd, f3: lf3, alo: la});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; alu_valid = 0; ld_issue_valid = 0; mem_rvalid = 0;
    @(posedge clk);
    #1 rst = 0;
    mq.delete(); m_err = 0; m_en = 0; m_rd = 0; m_data = 0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++; if (rf_en !== 1'b0) begin fails++; $display("FAIL reset_rf_en: got %b want 0", rf_en); end
    tests++; if (rf_rd !== 5'd0) begin fails++; $display("FAIL reset_rf_rd: got %0d want 0", rf_rd); end
    tests++; if (rf_data !== 32'd0) begin fails++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
    tests++; if (busy !== 32'd0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    idle();
    tests++; if (got_lr !== 1'b1) begin fails++; $display("FAIL reset_ld_ready: got %b want 1", got_lr); end
  endtask
  task automatic test_alu();
    cycle(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    tests++; if (got_ar !== 1'b1) begin fails++; $display("FAIL alu_ready: got %b want 1", got_ar); end
    tests++; if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h1234_5678)
      begin fails++; $display("FAIL alu_write: got en=%b rd=%0d data=%h want en=1 rd=5 data=12345678", rf_en, rf_rd, rf_data); end
    idle();
    tests++; if (rf_en !== 1'b0) begin fails++; $display("FAIL alu_one_cycle: got en=%b want 0", rf_en); end
    cycle(1, 0, 32'hCAFE_0001, 0, 0, 0, 0, 0, 0);
    tests++; if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'hCAFE_0001)
      begin fails++; $display("FAIL alu_x0: got en=%b rd=%0d data=%h want en=0 rd=0 data=cafe0001", rf_en, rf_rd, rf_data); end
  endtask
  task automatic test_load_format();
    cycle(0, 0, 0, 1, 7, 3'b000, 2'd3, 0, 0);
    tests++; if (busy[7] !== 1'b1) begin fails++; $display("FAIL lb_busy_set: got %b want 1", busy[7]); end
    idle();
    tests++; if (busy[7] !== 1'b1) begin fails++; $display("FAIL lb_busy_hold: got %b want 1", busy[7]); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h80AA_BBCC);
    tests++; if (rf_en !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hFFFF_FF80)
      begin fails++; $display("FAIL lb_sext: got en=%b rd=%0d data=%h want en=1 rd=7 data=ffffff80", rf_en, rf_rd, rf_data); end
    tests++; if (busy[7] !== 1'b0) begin fails++; $display("FAIL lb_busy_clear: got %b want 0", busy[7]); end
    cycle(0, 0, 0, 1, 9, 3'b101, 2'd2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h8001_0000);
    tests++; if (rf_rd !== 5'd9 || rf_data !== 32'h0000_8001)
      begin fails++; $display("FAIL lhu_zext: got rd=%0d data=%h want rd=9 data=00008001", rf_rd, rf_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL aligned_no_err: got %b want 0", err); end
  endtask
  task automatic test_alu_vs_load();
    cycle(0, 0, 0, 1, 3, 3'b010, 2'd0, 0, 0);
    cycle(1, 4, 32'hAAAA_0004, 0, 0, 0, 0, 1, 32'h5555_0003);
    tests++; if (got_ar !== 1'b0) begin fails++; $display("FAIL arb_alu_ready: got %b want 0", got_ar); end
    tests++; if (rf_rd !== 5'd3 || rf_data !== 32'h5555_0003)
      begin fails++; $display("FAIL arb_load_first: got rd=%0d data=%h want rd=3 data=55550003", rf_rd, rf_data); end
    cycle(1, 4, 32'hAAAA_0004, 0, 0, 0, 0, 0, 0);
    tests++; if (rf_en !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'hAAAA_0004)
      begin fails++; $display("FAIL arb_alu_next: got en=%b rd=%0d data=%h want en=1 rd=4 data=aaaa0004", rf_en, rf_rd, rf_data); end
  endtask
  task automatic test_queue_full();
    cycle(0, 0, 0, 1, 7, 3'b000, 2'd0, 0, 0);
    cycle(0, 0, 0, 1, 8, 3'b000, 2'd0, 0, 0);
    tests++; if (got_lr !== 1'b1) begin fails++; $display("FAIL full_second_accept: got %b want 1", got_lr); end
    cycle(1, 7, 32'h7777, 1, 10, 3'b000, 2'd0, 0, 0);
    tests++; if (got_lr !== 1'b0) begin fails++; $display("FAIL full_third_blocked: got %b want 0", got_lr); end
    tests++; if (got_ar !== 1'b0) begin fails++; $display("FAIL alu_busy_stall: got %b want 0", got_ar); end
    cycle(0, 0, 0, 1, 11, 3'b000, 2'd0, 1, 32'h1122_3344);
    tests++; if (got_lr !== 1'b0) begin fails++; $display("FAIL full_pre_pop: got %b want 0", got_lr); end
    tests++; if (rf_rd !== 5'd7 || rf_data !== 32'h44)
      begin fails++; $display("FAIL full_pop: got rd=%0d data=%h want rd=7 data=44", rf_rd, rf_data); end
    cycle(1, 8, 32'h8888, 1, 8, 3'b000, 2'd0, 0, 0);
    tests++; if (got_lr !== 1'b0) begin fails++; $display("FAIL busy_rd_issue: got %b want 0", got_lr); end
    tests++; if (got_ar !== 1'b0) begin fails++; $display("FAIL busy_rd_alu: got %b want 0", got_ar); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_00F0);
    tests++; if (rf_rd !== 5'd8 || rf_data !== 32'hFFFF_FFF0 || busy !== 32'd0)
      begin fails++; $display("FAIL drain: got rd=%0d data=%h busy=%h want rd=8 data=fffffff0 busy=0", rf_rd, rf_data, busy); end
  endtask
  task automatic test_reset_flush();
    cycle(0, 0, 0, 1, 12, 3'b010, 2'd0, 0, 0);
    cycle(0, 0, 0, 1, 13, 3'b010, 2'd0, 0, 0);
    do_reset();
    tests++; if (busy !== 32'd0) begin fails++; $display("FAIL flush_busy: got %h want 0", busy); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    tests++; if (rf_en !== 1'b0 || err !== 1'b1)
      begin fails++; $display("FAIL flush_unexpected: got en=%b err=%b want en=0 err=1", rf_en, err); end
  endtask
  task automatic test_misalign();
    do_reset();
    cycle(0, 0, 0, 1, 5, 3'b010, 2'd1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    tests++; if (err !== 1'b1 || rf_data !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL lw_misalign: got err=%b data=%h want err=1 data=deadbeef", err, rf_data); end
    do_reset();
    cycle(0, 0, 0, 1, 6, 3'b011, 2'd0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    tests++; if (err !== 1'b1 || rf_en !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'd0)
      begin fails++; $display("FAIL illegal_f3: got err=%b en=%b rd=%0d data=%h want err=1 en=1 rd=6 data=0", err, rf_en, rf_rd, rf_data); end
  endtask
  task automatic test_random();
    logic [2:0] f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd4, 3'd3};
    logic [2:0] f3;
    logic [1:0] la;
    bit rv;
    int bad_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 0) do_reset();
      f3 = f3s[$urandom_range(0, 7)];
      la = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) != 0) la = (f3 == 3'd2) ? 2'd0 : (f3 == 3'd1 || f3 == 3'd5) ? {la[1], 1'b0} : la;
      rv = mq.size() != 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 29) == 0;
      cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), f3, la, rv, $urandom);
      tests++; if (got_ar !== exp_ar) begin fails++; bad_cnt++; $display("FAIL rnd_alu_ready n=%0d: got %b want %b", n, got_ar, exp_ar); end
      tests++; if (got_lr !== exp_lr) begin fails++; bad_cnt++; $display("FAIL rnd_ld_ready n=%0d: got %b want %b", n, got_lr, exp_lr); end
      tests++; if (rf_en !== m_en || rf_rd !== m_rd || rf_data !== m_data)
        begin fails++; bad_cnt++; $display("FAIL rnd_write n=%0d: got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h", n, rf_en, rf_rd, rf_data, m_en, m_rd, m_data); end
      tests++; if (busy !== m_busy()) begin fails++; bad_cnt++; $display("FAIL rnd_busy n=%0d: got %h want %h", n, busy, m_busy()); end
      tests++; if (err !== m_err) begin fails++; bad_cnt++; $display("FAIL rnd_err n=%0d: got %b want %b", n, err, m_err); end
      if (bad_cnt > 20) break;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_issue_funct3 = 0; ld_issue_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0;
    test_reset();
    test_alu();
    test_load_format();
    test_alu_vs_load();
    test_queue_full();
    test_reset_flush();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
